// File: rtl/shift_reg_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : shift_reg_ctrl                                                |
// | Purpose  : Command-driven controller for an external universal shift     |
// |            register. Accepts load / shift-right / shift-left /           |
// |            rotate-right commands and sequences the register's mode,      |
// |            serial and parallel inputs for the requested number of steps. |
// | Ports    : clk, rst (async, active-low)                                  |
// |            cmd_valid/cmd_ready/cmd_op/cmd_count/cmd_data : command       |
// |            abort          : cancel the executing command                 |
// |            sr_q           : current register contents (rotate feedback)  |
// |            sr_mode        : 00 hold, 01 right, 10 left, 11 load          |
// |            sr_serial_in   : serial bit into the register                 |
// |            sr_parallel_in : parallel load value                          |
// |            busy, done, aborted : status                                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module shift_reg_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  input  logic [WIDTH-1:0] sr_q,
  output logic [1:0]       sr_mode,
  output logic             sr_serial_in,
  output logic [WIDTH-1:0] sr_parallel_in,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam logic [1:0] OP_LOAD    = 2'b00;
  localparam logic [1:0] OP_SHR     = 2'b01;
  localparam logic [1:0] OP_SHL     = 2'b10;
  localparam logic [1:0] OP_ROR     = 2'b11;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic             w_stepping;
  logic             w_last_step;
  logic [CNT_W-1:0] w_last_idx;
  logic             w_sr_q_unused;

  // Only the LSB of the register is needed (rotate feedback).
  assign w_sr_q_unused = ^sr_q[WIDTH-1:1];

  // An abort cancels the step in the very cycle it is raised.
  assign w_stepping  = (state_q == EXEC) && !abort;
  // cnt_q is never 0 in EXEC for shift/rotate, so this cannot underflow there.
  assign w_last_idx  = cnt_q - CNT_W'(1);
  assign w_last_step = (op_q == OP_LOAD) || (step_q == w_last_idx);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          cnt_d   = cmd_count;
          data_d  = cmd_data;
          step_d  = '0;
          state_d = ((cmd_op != OP_LOAD) && (cmd_count == '0)) ? FINISH : EXEC;
        end
      end
      EXEC: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (w_last_step) begin
            state_d = FINISH;
          end else begin
            step_d = step_q + CNT_W'(1);
          end
          // Rotating the latched data keeps the next source bit at data_q[0],
          // giving data[k mod WIDTH] on step k without a modulo.
          if ((op_q == OP_SHR) || (op_q == OP_SHL)) begin
            data_d = {data_q[0], data_q[WIDTH-1:1]};
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d   = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == FINISH);
    aborted_d = (state_q == EXEC) && abort;
  end

  // Register drive; combinational so abort and rotate feedback act in-cycle.
  always_comb begin
    sr_mode        = MODE_HOLD;
    sr_serial_in   = 1'b0;
    sr_parallel_in = '0;
    if (w_stepping) begin
      case (op_q)
        OP_LOAD: begin
          sr_mode        = MODE_LOAD;
          sr_parallel_in = data_q;
        end
        OP_SHR: begin
          sr_mode      = MODE_RIGHT;
          sr_serial_in = data_q[0];
        end
        OP_SHL: begin
          sr_mode      = MODE_LEFT;
          sr_serial_in = data_q[0];
        end
        default: begin
          sr_mode      = MODE_RIGHT;
          sr_serial_in = sr_q[0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      op_q      <= OP_LOAD;
      cnt_q     <= '0;
      step_q    <= '0;
      data_q    <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule
`default_nettype wire

// File: doc/shift_reg_ctrl.md
SHIFT_REG_CTRL -- requirements
Module: shift_reg_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, datapath width of the controlled universal shift register.
REQ-002 Parameter: CNT_W, 3, width of the shift-count field; maximum count is 2**CNT_W-1.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset; 0 resets immediately, independent of clk.
REQ-005 Port: cmd_valid  input  1  command present.
REQ-006 Port: cmd_ready  output  1  controller can accept a command.
REQ-007 Port: cmd_op  input  2  00 load, 01 shift right, 10 shift left, 11 rotate right.
REQ-008 Port: cmd_count  input  CNT_W  number of shift/rotate steps (ignored for load).
REQ-009 Port: cmd_data  input  WIDTH  load value (op 00) or serial-source bits (ops 01/10).
REQ-010 Port: abort  input  1  synchronous cancel of the executing command.
REQ-011 Port: sr_q  input  WIDTH  current contents of the controlled register.
REQ-012 Port: sr_mode  output  2  register mode: 00 hold, 01 right, 10 left, 11 parallel load.
REQ-013 Port: sr_serial_in  output  1  serial bit to register.
REQ-014 Port: sr_parallel_in  output  WIDTH  parallel load value to register.
REQ-015 Port: busy  output  1  command executing.
REQ-016 Port: done  output  1  one-cycle pulse on normal completion.
REQ-017 Port: aborted  output  1  one-cycle pulse on abort.

Function
REQ-018 FSM states SHALL be IDLE, EXEC and FINISH; the reset state is IDLE.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1, latching cmd_op, cmd_count and cmd_data.
REQ-020 On acceptance: op 00, or count 0 with op 01/10/11, SHALL go to FINISH if the op needs no steps, otherwise to EXEC.
REQ-021 In EXEC, sr_mode SHALL carry the op's mode (load 11, right 01, left 10, rotate 01) for exactly N consecutive cycles, then return to 00; N=1 for load and N=count otherwise.
REQ-022 Every cycle outside those N cycles, sr_mode SHALL be 00.
REQ-023 For op 00, sr_parallel_in SHALL equal the latched cmd_data during the load cycle; at all other times it SHALL be 0.
REQ-024 For ops 01/10, sr_serial_in on step k (k=0..N-1) SHALL equal latched cmd_data[k mod WIDTH].
REQ-025 For op 11, sr_serial_in SHALL equal sr_q[0], combinationally, on every step; the register rotates right.
REQ-026 In all other cycles, sr_serial_in SHALL be 0.
REQ-027 After the last step, the controller SHALL enter FINISH for one cycle with done=1, then return to IDLE.
REQ-028 A count-0 shift or rotate SHALL produce no non-hold sr_mode cycle: accept -> FINISH (done=1) -> IDLE.
REQ-029 busy SHALL be 1 in EXEC and FINISH and 0 in IDLE.
REQ-030 abort=1 in EXEC SHALL force sr_mode=00 in that cycle and move to IDLE on the next edge with aborted=1 for one cycle and done=0; steps already applied are not undone.
REQ-031 abort in IDLE or FINISH SHALL be ignored.
REQ-032 cmd_valid held high during EXEC or FINISH SHALL NOT be accepted; the next acceptance is possible the cycle after FINISH/abort.
REQ-033 The step counter SHALL be CNT_W bits and SHALL NOT wrap; count 2**CNT_W-1 yields exactly that many steps.

Reset
REQ-034 While rst=0: state IDLE; cmd_ready=1; busy, done, aborted=0; sr_mode=00; sr_serial_in=0; sr_parallel_in=0; latched command cleared.
REQ-035 Reset asserted mid-EXEC SHALL immediately drive sr_mode=00 and suppress done/aborted; the command is lost.
REQ-036 After rst deasserts, a command SHALL be accepted on the first rising edge with cmd_valid=1.

Verification
REQ-037 Load: op 00, data 1010 -> one cycle sr_mode=11, sr_parallel_in=1010; next cycle done=1; register reads 1010.
REQ-038 Shift right: register 0000, op 01, count 3, data 0101 -> three cycles sr_mode=01 with serial 1,0,1; register 1010; done one cycle later.
REQ-039 Rotate: register 0001, op 11, count 5 -> five sr_mode=01 cycles with serial=sr_q[0]; register 1000; done=1.
REQ-040 Count 0: op 10, count 0 -> sr_mode stays 00, done=1 the cycle after acceptance, cmd_ready=1 the cycle after that.
REQ-041 Abort: op 10, count 7, abort on the 3rd step -> only 2 left shifts applied, aborted=1, done never 1, back to IDLE.
REQ-042 Reset mid-op: rst=0 during a count-6 shift -> sr_mode=00 and busy=0 immediately; after release, a new load succeeds.
